button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Input conditioning stage directly upstream of the 4-bit CPU's pushbutton tristate (oeIn path).
- Takes the raw asynchronous pushbuttons (ui_in[3:0]) and synchronizes each one, then debounces it.
- Presents two views on one 4-bit bus: the stable button levels, or sticky press-event flags.
- When the CPU acknowledges a read in event view, the press-event flags are cleared.

Parameters:
- DEBOUNCE_COUNT, 16'd50_000, consecutive cycles a synchronized input must differ from the stable level before the stable level flips; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of each per-channel debounce counter.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous reset, active-high.
- btn_raw  input  4  raw pushbuttons, asynchronous, active-high (1 = pressed).
- sel  input  1  data_out view select: 0 = stable levels, 1 = press events.
- read_ack  input  1  one-cycle CPU read strobe; clears events only when sel=1.
- data_out  output  4  sel ? btn_event : btn_level; combinational mux of registered state.
- btn_level  output  4  debounced stable level per channel.
- btn_event  output  4  sticky per-channel press flags, one per 0->1 transition of btn_level.
- event_pending  output  1  OR of btn_event.

Behaviour:
- Reset, synchronous, on any edge with reset=1:
  - Cleared: sync1, sync2, btn_level, btn_event and all counters.
  - Outputs read 0, including event_pending and data_out.
  - This also applies mid-debounce; a partially counted transition is discarded.
- Synchronizer:
  - Per channel, a 2-flop chain: sync1 <= btn_raw, then sync2 <= sync1.
  - Only sync2 feeds the debounce logic.
- Debounce, per channel i, evaluated each edge:
  - If sync2[i] == btn_level[i], then cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_COUNT-1, then btn_level[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise, cnt[i] <= cnt[i]+1.
- Latency:
  - If raw changes before edge k and is captured into sync1 at edge k, btn_level updates at edge k+1+DEBOUNCE_COUNT.
  - With DEBOUNCE_COUNT=1 the block is a pure 2-flop synchronizer plus 1 cycle.
- Glitch rejection:
  - A raw pulse that leaves sync2 differing for fewer than DEBOUNCE_COUNT consecutive cycles never changes btn_level.
  - Its counter returns to 0 as soon as sync2 matches btn_level again.
- Counter bound: cnt never exceeds DEBOUNCE_COUNT-1, so there is no wrap.
- Channel independence: the four channels are fully independent; simultaneous transitions on several channels each follow their own counter.
- Event set:
  - On the same edge btn_level[i] goes 0->1, btn_event[i] <= 1.
  - The flag is visible in the same cycle as the new level.
  - A release (1->0) does not set or clear it.
- Event clear:
  - On an edge with read_ack=1 and sel=1, btn_event <= 0 for every channel not being set on that edge.
  - Set has priority: a press landing on the ack edge leaves its flag at 1.
  - read_ack with sel=0 has no effect.
- Sticky behaviour: repeated presses before an ack leave the flag at 1; there is no counting.
- data_out is a pure mux with no extra latency.
- The CPU samples it through its tristate in the same cycle.

Test Plan:
- Reset: DEBOUNCE_COUNT=4, hold reset 2 cycles with btn_raw=4'hF -> btn_level=0, btn_event=0, event_pending=0 during reset and on the first cycle after.
- Clean press: DEBOUNCE_COUNT=4, btn_raw 0->4'b0001 before edge 0 -> btn_level=4'b0001 and btn_event=4'b0001 first visible after edge 5, not after edge 4; event_pending=1.
- Glitch: DEBOUNCE_COUNT=4, btn_raw[2]=1 for 3 cycles then 0 -> btn_level[2] stays 0, no event, cnt[2] back to 0.
- Bounce: DEBOUNCE_COUNT=4, btn_raw[1] toggling 1,0,1,0 each cycle, then held 1 -> single 0->1 on btn_level[1], 5 edges after the final sync1 capture; btn_event[1]=1.
- Read/ack: events=4'b0101, sel=1 -> data_out=4'b0101.
  - Pulse read_ack -> events=0 next cycle.
  - Repeat with sel=0 and read_ack=1 -> events unchanged, data_out=btn_level.
- Set/clear collision: btn_level[3] rises on the same edge as read_ack=1 with sel=1, and btn_event[0]=1 beforehand -> after the edge btn_event=4'b1000.
- Reset mid-debounce: reset at cycle 2 of a 4-cycle debounce -> no level change until a fresh full debounce completes.

Source files
------------

// File: rtl/button_conditioner.sv
// Pushbutton input conditioner: 2-flop synchronizer, per-channel debounce
// down to a stable level, and sticky press-event flags that the CPU clears
// by acknowledging a read in event view.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_COUNT = 50_000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       sel,
    input  logic       read_ack,
    output logic [3:0] data_out,
    output logic [3:0] btn_level,
    output logic [3:0] btn_event,
    output logic       event_pending
);

    // Terminal count: the stable level flips on the DEBOUNCE_COUNT-th
    // consecutive differing sample, so the counter never passes this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       level_q;
    logic [3:0]       level_d;
    logic [3:0]       event_q;
    logic [3:0]       event_d;
    logic [3:0]       rise;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Per-channel debounce: count consecutive disagreements, flip on terminal count.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Event flags: a rising stable level sets its flag and wins over an ack clear.
    always_comb begin
        rise    = level_d & ~level_q;
        event_d = event_q;
        if (read_ack && sel) begin
            event_d = 4'b0000;
        end
        event_d = event_d | rise;
    end

    // State registers with synchronous reset; reset discards any partial count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            level_q <= 4'b0000;
            event_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            event_q <= event_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // The CPU samples data_out through its tristate in the same cycle, so no register here.
    assign data_out      = sel ? event_q : level_q;
    assign btn_level     = level_q;
    assign btn_event     = event_q;
    assign event_pending = |event_q;

endmodule
